// File: rtl/mul_acc_dec_pkg.sv
// mul_acc_dec_pkg: shared helpers and default coefficient half-bank for the polyphase decimator
package mul_acc_dec_pkg;
    localparam int c_default_taps = 27;
    localparam int c_default_cw   = 16;

    function automatic int cdiv(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic logic [c_default_taps*c_default_cw-1:0] default_coeff();
        logic [c_default_taps*c_default_cw-1:0] c;
        for (int i = 0; i < c_default_taps; i++) c[i*c_default_cw +: c_default_cw] = 16'((i + 1) * 1200);
        return c;
    endfunction

    localparam logic [c_default_taps*c_default_cw-1:0] c_default_coeff = default_coeff();
endpackage

// File: rtl/mul_acc_dec_col.sv
// mul_acc_dec_col: one transposed-form column MAC; loads from the next column on r==0, accumulates otherwise
module mul_acc_dec_col #(
    parameter int iw = 8,
    parameter int cw = 16,
    parameter int ow = 27
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          r_is_zero,
    input  logic [iw-1:0] x,
    input  logic [cw-1:0] coeff,
    input  logic [ow-1:0] acc_in,
    output logic [ow-1:0] acc
);
    logic signed [iw+cw-1:0] prod;
    assign prod = $signed(x) * $signed(coeff);
    always_ff @(posedge clk or posedge rst)
        if (rst) acc <= '0;
        else if (ena) acc <= (r_is_zero ? acc_in : acc) + ow'(prod);
endmodule

// File: rtl/mul_acc_dec.sv
// mul_acc_dec: polyphase decimating FIR, transposed form with ceil(L/M) column MACs, full-precision output
module mul_acc_dec
    import mul_acc_dec_pkg::*;
#(
    parameter int gp_idata_width       = 8,
    parameter int gp_decimation_factor = 32,
    parameter int gp_coeff_length      = 53,
    parameter int gp_coeff_width       = 16,
    parameter int gp_odata_width       = gp_idata_width + gp_coeff_width + $clog2(gp_coeff_length),
    parameter logic [cdiv(gp_coeff_length, 2)*gp_coeff_width-1:0] gp_coeff = c_default_coeff
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_ena,
    input  logic [gp_idata_width-1:0]               i_data,
    output logic [gp_odata_width-1:0]               o_data,
    output logic                                    o_valid,
    output logic [$clog2(gp_decimation_factor)-1:0] o_phase
);
    localparam int c_col        = cdiv(gp_coeff_length, gp_decimation_factor);
    localparam int c_half       = cdiv(gp_coeff_length, 2);
    localparam int c_prod_width = gp_idata_width + gp_coeff_width;
    localparam int pw           = $clog2(gp_decimation_factor);

    function automatic logic signed [gp_coeff_width-1:0] h_of(input int k);
        int i;
        i = k >= gp_coeff_length ? 0 : k < c_half ? k : gp_coeff_length - 1 - k;
        return k >= gp_coeff_length ? '0 : gp_coeff[i*gp_coeff_width +: gp_coeff_width];
    endfunction

    logic [pw-1:0]                r;
    logic [gp_odata_width-1:0]    acc [c_col+1];
    logic signed [c_prod_width-1:0] prod0;

    assign acc[c_col] = '0;
    assign o_phase    = r;
    assign prod0      = $signed(i_data) * h_of(0);

    // p = M-r; at r==0 this selects h[(j+1)*M], the tap that rides along with the shift
    for (genvar j = 0; j < c_col; j++) begin : g_col
        logic signed [gp_coeff_width-1:0] coeff;
        always_comb coeff = h_of(j * gp_decimation_factor + gp_decimation_factor - int'(r));
        mul_acc_dec_col #(
            .iw(gp_idata_width),
            .cw(gp_coeff_width),
            .ow(gp_odata_width)
        ) u_col (
            .clk      (i_clk),
            .rst      (i_rst),
            .ena      (i_ena),
            .r_is_zero(r == '0),
            .x        (i_data),
            .coeff    (coeff),
            .acc_in   (acc[j+1]),
            .acc      (acc[j])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r       <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_ena && r == '0;
            if (i_ena) begin
                r <= r == pw'(gp_decimation_factor - 1) ? '0 : r + 1'b1;
                if (r == '0) o_data <= acc[0] + gp_odata_width'(prod0);
            end
        end
endmodule

// File: tb/tb_mul_acc_dec.sv
// tb_mul_acc_dec: directed-vector bench for the decimator at M=4, L=8, h={1,2,3,4,4,3,2,1}
module tb_mul_acc_dec;
    localparam int ow = 8 + 16 + 3;

    logic          clk, rst, ena;
    logic [7:0]    data, data2;
    logic [ow-1:0] o_data, o_data2;
    logic          o_valid, o_valid2;
    logic [1:0]    o_phase, o_phase2;
    int            errors = 0, checks = 0;

    mul_acc_dec #(
        .gp_idata_width(8), .gp_decimation_factor(4), .gp_coeff_length(8), .gp_coeff_width(16),
        .gp_coeff({16'd4, 16'd3, 16'd2, 16'd1})
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(data),
        .o_data(o_data), .o_valid(o_valid), .o_phase(o_phase)
    );

    mul_acc_dec #(
        .gp_idata_width(8), .gp_decimation_factor(4), .gp_coeff_length(8), .gp_coeff_width(16),
        .gp_coeff({4{16'h7fff}})
    ) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_data(data2),
        .o_data(o_data2), .o_valid(o_valid2), .o_phase(o_phase2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        ena = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic feed(input logic e, input int x);
        @(negedge clk);
        ena  = e;
        data = 8'(x);
        @(posedge clk);
        #1;
    endtask

    // kind: 0 impulse at m=0, 1 impulse at m=1, 2 DC 10 continuous, 3 DC 10 with ena 1-0-1
    task automatic stream(input string tag, input int kind, input bit with_reset, input longint ys[4]);
        longint ys2[4] = '{-128 * 32767, -128 * 32767 * 5, -128 * 32767 * 8, -128 * 32767 * 8};
        int m = 0, r = 0, k = 0, c = 0, x;
        bit e;
        if (with_reset) do_reset();
        while (m < 16) begin
            e = kind == 3 ? (c % 3 != 1) : 1'b1;
            x = kind == 0 ? int'(m == 0) : kind == 1 ? int'(m == 1) : 10;
            if (!e) x = 99;
            feed(e, x);
            check({tag, " valid"}, o_valid, e && r == 0);
            if (e && r == 0) begin
                check({tag, " data"}, $signed(o_data), ys[k]);
                if (kind == 2) check({tag, " fullw data"}, $signed(o_data2), ys2[k]);
                k++;
            end
            if (e) begin
                r = (r + 1) % 4;
                m++;
            end
            check({tag, " phase"}, o_phase, r);
            c++;
        end
    endtask

    initial begin
        data2 = 8'h80;
        data  = '0;
        do_reset();
        check("reset data", $signed(o_data), 0);
        check("reset valid", o_valid, 0);
        check("reset phase", o_phase, 0);
        stream("imp0", 0, 1'b1, '{1, 4, 0, 0});
        stream("imp1", 1, 1'b1, '{0, 4, 1, 0});
        stream("dc", 2, 1'b1, '{10, 140, 200, 200});
        stream("toggle", 3, 1'b1, '{10, 140, 200, 200});
        do_reset();
        for (int m = 0; m < 7; m++) feed(1'b1, 10);
        check("pre-rst data", $signed(o_data), 140);
        check("pre-rst phase", o_phase, 3);
        ena = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst data", $signed(o_data), 0);
        check("async rst valid", o_valid, 0);
        check("async rst phase", o_phase, 0);
        @(negedge clk);
        rst = 1'b0;
        stream("restart", 2, 1'b0, '{10, 140, 200, 200});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
